seven_seg_scan_ctrl: RTL and testbench

Scan controller for the 8-digit multiplexed seven-segment display. It time-multiplexes one hex digit at a time into the existing hex-to-segment driver and one-hot anode path. It double-buffers a 32-bit display word behind a valid/ready handshake, and commits new words only at frame boundaries so the display never tears. It also provides leading-zero blanking and an 8-level brightness (anode duty) control.

---
 rtl/seven_seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 8-digit seven-segment scan controller
// Double-buffered display word, frame-aligned commit, leading-zero blanking, duty dimming.
module seven_seg_scan_ctrl #(
  parameter int unsigned SLOT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic        wr_lzb,
  input  logic [2:0]  bright,
  output logic [3:0]  digit,
  output logic [7:0]  an_sel,
  output logic        dp_out,
  output logic        frame_done
);

  localparam int unsigned CW  = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned SEG = SLOT_CYCLES / 8;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] slot_q, slot_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   act_data_q, act_data_d;
  logic [7:0]    act_dp_q, act_dp_d;
  logic          act_lzb_q, act_lzb_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic          pend_lzb_q, pend_lzb_d;
  logic          pend_full_q, pend_full_d;
  logic [3:0]    digit_q, digit_d;
  logic [7:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic          commit;
  logic [31:0]   thr;
  logic          lit;
  logic [7:0]    blank;

  assign wr_ready   = ~pend_full_q;
  assign digit      = digit_q;
  assign an_sel     = an_q;
  assign dp_out     = dp_q;
  assign frame_done = fd_q;

  always_comb begin
    slot_end  = (slot_q == SLOT_LAST);
    frame_end = enable && slot_end && (idx_q == 3'd7);
    accept    = wr_valid && !pend_full_q;
    // With the scan stopped there is no frame boundary to wait for.
    commit    = pend_full_q && (frame_end || !enable);
    thr       = (32'(bright) + 32'd1) * 32'(SEG);
    lit       = 32'(slot_q) < thr;

    // A digit blanks only if everything to its left is already blank.
    blank    = 8'h00;
    blank[7] = act_lzb_q && (act_data_q[31:28] == 4'd0) && !act_dp_q[7];
    for (int k = 6; k >= 1; k--) begin
      blank[k] = blank[k+1] && (act_data_q[4*k +: 4] == 4'd0) && !act_dp_q[k];
    end
  end

  always_comb begin
    slot_d      = slot_q;
    idx_d       = idx_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_lzb_d   = act_lzb_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_lzb_d  = pend_lzb_q;
    pend_full_d = pend_full_q;

    if (!enable) begin
      slot_d = '0;
      idx_d  = 3'd0;
    end else if (slot_end) begin
      slot_d = '0;
      idx_d  = idx_q + 3'd1;
    end else begin
      slot_d = slot_q + CW'(1);
    end

    // accept and commit are mutually exclusive: one needs pending empty, the other full.
    if (commit) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_lzb_d   = pend_lzb_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_data_d = wr_data;
      pend_dp_d   = wr_dp;
      pend_lzb_d  = wr_lzb;
      pend_full_d = 1'b1;
    end

    digit_d = act_data_q[{idx_q, 2'b00} +: 4];
    dp_d    = act_dp_q[idx_q];
    an_d    = (enable && lit && !blank[idx_q]) ? (8'd1 << idx_q) : 8'd0;
    fd_d    = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      idx_q       <= 3'd0;
      act_data_q  <= 32'd0;
      act_dp_q    <= 8'd0;
      act_lzb_q   <= 1'b0;
      pend_data_q <= 32'd0;
      pend_dp_q   <= 8'd0;
      pend_lzb_q  <= 1'b0;
      pend_full_q <= 1'b0;
      digit_q     <= 4'd0;
      an_q        <= 8'd0;
      dp_q        <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_lzb_q   <= act_lzb_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_lzb_q  <= pend_lzb_d;
      pend_full_q <= pend_full_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - scoreboard bench for seven_seg_scan_ctrl
// A behavioural model predicts each cycle's registered outputs; predictions are queued and popped after the edge.
module tb_seven_seg_scan_ctrl;

  localparam int SC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = 32'd0;
  logic [7:0]  wr_dp = 8'd0;
  logic        wr_lzb = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic [3:0]  digit;
  logic [7:0]  an_sel;
  logic        dp_out;
  logic        frame_done;

  seven_seg_scan_ctrl #(.SLOT_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_lzb(wr_lzb), .bright(bright),
    .digit(digit), .an_sel(an_sel), .dp_out(dp_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic [7:0] a;
    logic       p;
    logic       f;
  } out_t;

  out_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int          m_slot, m_idx;
  logic [31:0] m_adata, m_pdata;
  logic [7:0]  m_adp, m_pdp;
  logic        m_alzb, m_plzb, m_pfull;
  logic        accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_idx = 0;
    m_adata = 0; m_adp = 0; m_alzb = 0;
    m_pdata = 0; m_pdp = 0; m_plzb = 0; m_pfull = 0;
    accepted = 0;
    exp_q.delete();
  endtask

  function automatic out_t model_out();
    out_t o;
    logic [7:0] bl;
    logic above;
    above = 1'b1;
    bl = 8'h00;
    for (int k = 7; k >= 1; k--) begin
      if (m_alzb && above && m_adata[4*k +: 4] == 4'd0 && !m_adp[k]) bl[k] = 1'b1;
      else above = 1'b0;
    end
    o.d = m_adata[4*m_idx +: 4];
    o.p = m_adp[m_idx];
    o.a = (enable && m_slot < (int'(bright) + 1) * (SC / 8) && !bl[m_idx]) ? 8'(1 << m_idx) : 8'h00;
    o.f = enable && m_slot == SC - 1 && m_idx == 7;
    return o;
  endfunction

  task automatic model_step();
    logic fe;
    fe = enable && m_slot == SC - 1 && m_idx == 7;
    accepted = wr_valid && !m_pfull;
    if (m_pfull && (fe || !enable)) begin
      m_adata = m_pdata; m_adp = m_pdp; m_alzb = m_plzb; m_pfull = 1'b0;
    end else if (accepted) begin
      m_pdata = wr_data; m_pdp = wr_dp; m_plzb = wr_lzb; m_pfull = 1'b1;
    end
    if (!enable) begin
      m_slot = 0; m_idx = 0;
    end else if (m_slot == SC - 1) begin
      m_slot = 0; m_idx = (m_idx + 1) % 8;
    end else begin
      m_slot++;
    end
  endtask

  task automatic tick();
    out_t o;
    exp_q.push_back(model_out());
    model_step();
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check("digit", 32'(digit), 32'(o.d));
    check("an_sel", 32'(an_sel), 32'(o.a));
    check("dp_out", 32'(dp_out), 32'(o.p));
    check("frame_done", 32'(frame_done), 32'(o.f));
    check("wr_ready", 32'(wr_ready), 32'(!m_pfull));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_an_sel", 32'(an_sel), 32'h00);
    check("rst_digit", 32'(digit), 32'h0);
    check("rst_dp_out", 32'(dp_out), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_word(input logic [31:0] d, input logic [7:0] dp, input logic lzb);
    logic got;
    got = 1'b0;
    wr_valid = 1'b1; wr_data = d; wr_dp = dp; wr_lzb = lzb;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      got = accepted;
    end
    wr_valid = 1'b0;
    wr_data = $urandom;
    wr_dp = 8'($urandom);
    check("write_accept", 32'(got), 32'd1);
  endtask

  task automatic wait_frame_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = (frame_done === 1'b1);
    end
    check("frame_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_frame_digits(input string tag, input logic [31:0] w);
    for (int s = 0; s < 8; s++) begin
      check(tag, 32'(digit), 32'(w[4*s +: 4]));
      ticks(SC);
    end
  endtask

  initial begin
    int pulses;
    int lit_cnt;
    logic [31:0] wa, wb, wc;
    logic [7:0] exp_an;

    #2;
    enable = 1'b1;
    bright = 3'd7;
    do_reset();

    // free scan: two frames, exactly two frame_done pulses
    pulses = 0;
    for (int i = 0; i < 2 * 8 * SC; i++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
    end
    check("frame_pulses", 32'(pulses), 32'd2);

    // handshake and commit mid-frame
    ticks(20);
    write_word(32'h1234_5678, 8'h00, 1'b0);
    check("ready_drop", 32'(wr_ready), 32'd0);
    wait_frame_done();
    check("ready_rise", 32'(wr_ready), 32'd1);
    tick();
    check_frame_digits("seq_12345678", 32'h1234_5678);

    // back-pressure: second word waits for first commit
    wa = 32'hA1A2_A3A4;
    wb = 32'hB5B6_B7B8;
    write_word(wa, 8'h0F, 1'b0);
    write_word(wb, 8'hF0, 1'b0);
    wait_frame_done();
    tick();
    check_frame_digits("seq_word_b", wb);

    // write accepted exactly in the frame_done cycle
    wc = 32'h9ABC_DEF1;
    for (int i = 0; i < 200 && !(m_slot == SC - 1 && m_idx == 7 && !m_pfull); i++) tick();
    wr_valid = 1'b1; wr_data = wc; wr_dp = 8'h00; wr_lzb = 1'b0;
    tick();
    wr_valid = 1'b0;
    check("collision_accept", 32'(accepted), 32'd1);
    check("collision_fd", 32'(frame_done), 32'd1);
    tick();
    check("collision_old", 32'(digit), 32'(wb[3:0]));
    wait_frame_done();
    tick();
    check("collision_new", 32'(digit), 32'(wc[3:0]));

    // brightness 2/8 duty over one full frame of states
    bright = 3'd1;
    lit_cnt = 0;
    for (int i = 0; i < 8 * SC; i++) begin
      tick();
      if (an_sel !== 8'h00) lit_cnt++;
    end
    check("duty_bright1", 32'(lit_cnt), 32'd16);
    bright = 3'd7;

    // drop enable mid-slot 5, write while dark, then re-enable
    for (int i = 0; i < 200 && !(m_idx == 5 && m_slot == 3); i++) tick();
    enable = 1'b0;
    tick();
    check("disable_dark", 32'(an_sel), 32'h00);
    ticks(3);
    write_word(32'h1234_5678, 8'h00, 1'b0);
    ticks(2);
    enable = 1'b1;
    tick();
    check("resume_an", 32'(an_sel), 32'h01);
    check("resume_digit", 32'(digit), 32'h8);

    // leading-zero blanking
    write_word(32'h0000_0050, 8'h00, 1'b1);
    wait_frame_done();
    tick();
    for (int s = 0; s < 8; s++) begin
      exp_an = (s == 0) ? 8'h01 : (s == 1) ? 8'h02 : 8'h00;
      check("lzb_an", 32'(an_sel), 32'(exp_an));
      ticks(SC);
    end
    write_word(32'h0000_0000, 8'h08, 1'b1);
    wait_frame_done();
    tick();
    for (int s = 0; s < 8; s++) begin
      exp_an = (s <= 3) ? 8'(1 << s) : 8'h00;
      check("lzb_dp_an", 32'(an_sel), 32'(exp_an));
      ticks(SC);
    end

    // reset while a word is pending: word is discarded
    write_word(32'hDEAD_BEEF, 8'hFF, 1'b0);
    ticks(3);
    #3;
    do_reset();
    ticks(8 * SC + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
